// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_if
// Description : Memory bus between the control unit (master) and the
//               instruction/data memory (slave).
//               mem_addr  [15:0]  access address
//               mem_rd            read strobe, held until mem_ready
//               mem_wr            write strobe, held until mem_ready
//               mem_wdata [15:0]  write data, stable while mem_wr is held
//               mem_rdata [15:0]  read data, valid with mem_ready
//               mem_ready         access complete in this cycle
// Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle instruction sequencer for a 16-bit datapath.
//               Fetches ir = {opcode, dest, a, b}, drives the datapath
//               register selects / ALU op / load enable, and performs
//               immediate, load, store, branch and jump sequences over a
//               ready-handshaked memory bus.
// Ports       : clk, rst_n           clock, async active-low reset
//               bus (master)         memory bus (addr/rd/wr/wdata/rdata/ready)
//               load_en, const_sel, data_sel, a_sel, b_sel, dest_sel,
//               op_sel, const_in     datapath controls
//               a_out, b_out, z      datapath results and zero flag
//               halted, bus_err      status
// Options     : CU_BUS_TIMEOUT_EN    when defined, a bus access that waits
//               16 cycles without mem_ready is abandoned, bus_err is set and
//               the controller parks in an error state until reset.
// Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [3:0]  PASS_B_OP = 4'hF
) (
    input  wire            clk,
    input  wire            rst_n,
    control_unit_if.master bus,
    output logic           load_en,
    output logic           const_sel,
    output logic           data_sel,
    output logic [3:0]     a_sel,
    output logic [3:0]     b_sel,
    output logic [3:0]     dest_sel,
    output logic [3:0]     op_sel,
    output logic [15:0]    const_in,
    input  wire  [15:0]    a_out,
    input  wire  [15:0]    b_out,
    input  wire            z,
    output logic           halted,
    output logic           bus_err
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_IMM    = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
`ifdef CU_BUS_TIMEOUT_EN
        , ST_ERR  = 3'd5
`endif
    } state_t;

    localparam logic [3:0] c_op_ldi = 4'hA;
    localparam logic [3:0] c_op_ld  = 4'hB;
    localparam logic [3:0] c_op_st  = 4'hC;
    localparam logic [3:0] c_op_bz  = 4'hD;
    localparam logic [3:0] c_op_jmp = 4'hE;
    localparam logic [3:0] c_op_hlt = 4'hF;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        zflag_q, zflag_d;
    // Cleared by reset so that no strobe is driven while rst_n is low; the
    // first fetch then starts on the first clock edge after release.
    logic        run_q, run_d;

    logic [15:0] w_mem_addr;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic [15:0] w_mem_wdata;
    logic [3:0]  w_opcode;

    assign w_opcode = ir_q[15:12];
    assign dest_sel = ir_q[11:8];
    assign a_sel    = ir_q[7:4];
    assign b_sel    = ir_q[3:0];

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_wdata = w_mem_wdata;

`ifdef CU_BUS_TIMEOUT_EN
    logic [3:0] tmo_q, tmo_d;
    logic       bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        zflag_d     = zflag_q;
        run_d       = 1'b1;
        w_mem_addr  = pc_q;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_wdata = 16'h0000;
        load_en     = 1'b0;
        const_sel   = 1'b0;
        data_sel    = 1'b0;
        op_sel      = 4'h0;
        const_in    = 16'h0000;

        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    w_mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        ir_d    = bus.mem_rdata;
                        pc_d    = pc_q + 16'd1;
                        state_d = ST_DECODE;
                    end
                end
            end

            ST_DECODE: begin
                case (w_opcode)
                    c_op_ldi, c_op_bz, c_op_jmp: state_d = ST_IMM;
                    c_op_ld, c_op_st:            state_d = ST_MEM;
                    c_op_hlt:                    state_d = ST_HALT;
                    default: begin
                        // Opcodes 0x0-0x9 are single-cycle ALU operations.
                        op_sel  = w_opcode;
                        load_en = 1'b1;
                        zflag_d = z;
                        state_d = ST_FETCH;
                    end
                endcase
            end

            ST_IMM: begin
                w_mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                    case (w_opcode)
                        c_op_ldi: begin
                            const_in  = bus.mem_rdata;
                            const_sel = 1'b1;
                            op_sel    = PASS_B_OP;
                            load_en   = 1'b1;
                            pc_d      = pc_q + 16'd1;
                        end
                        c_op_jmp: pc_d = bus.mem_rdata;
                        default:  pc_d = zflag_q ? bus.mem_rdata : pc_q + 16'd1;
                    endcase
                end
            end

            ST_MEM: begin
                w_mem_addr = a_out;
                if (w_opcode == c_op_st) begin
                    w_mem_wr    = 1'b1;
                    w_mem_wdata = b_out;
                    if (bus.mem_ready) state_d = ST_FETCH;
                end else begin
                    // Datapath data_in is wired to mem_rdata outside this block.
                    w_mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        data_sel = 1'b1;
                        load_en  = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end

            ST_HALT: state_d = ST_HALT;

`ifdef CU_BUS_TIMEOUT_EN
            ST_ERR:  state_d = ST_ERR;
`endif

            default: state_d = ST_FETCH;
        endcase

`ifdef CU_BUS_TIMEOUT_EN
        // Count cycles a strobe is held without completion; the 16th such
        // cycle abandons the access.
        tmo_d     = 4'd0;
        bus_err_d = bus_err_q;
        if ((w_mem_rd || w_mem_wr) && !bus.mem_ready) begin
            if (tmo_q == 4'hF) begin
                state_d   = ST_ERR;
                bus_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 4'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            zflag_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
            run_q   <= run_d;
        end
    end

`ifdef CU_BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= 4'd0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
    assign halted  = (state_q == ST_HALT) || (state_q == ST_ERR);
`else
    assign bus_err = 1'b0;
    assign halted  = (state_q == ST_HALT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. Directed vector table
//               of short programs with hand-computed results, plus sequences
//               for reset, wait states, halt and bus timeout.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        load_en, const_sel, data_sel;
    logic [3:0]  a_sel, b_sel, dest_sel, op_sel;
    logic [15:0] const_in;
    logic [15:0] a_out, b_out;
    logic        z;
    logic        halted, bus_err;

    control_unit_if bus ();

    control_unit #(
        .RESET_PC  (16'h0000),
        .PASS_B_OP (4'hF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .load_en   (load_en),
        .const_sel (const_sel),
        .data_sel  (data_sel),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .dest_sel  (dest_sel),
        .op_sel    (op_sel),
        .const_in  (const_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .z         (z),
        .halted    (halted),
        .bus_err   (bus_err)
    );

    // Memory model: combinational read, ready after a programmable number
    // of wait cycles counted while the strobe is held.
    logic [15:0] mem [0:255];
    int          rd_delay, wr_delay, wait_cnt;
    logic        force_ready;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    assign bus.mem_ready = force_ready
                         | (bus.mem_rd && (wait_cnt >= rd_delay))
                         | (bus.mem_wr && (wait_cnt >= wr_delay));

    always @(posedge clk) begin
        if ((bus.mem_rd || bus.mem_wr) && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
        else                                              wait_cnt <= 0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fill_mem(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] whi);
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        mem[0]   = w0;
        mem[1]   = w1;
        mem[2]   = w2;
        mem[255] = whi;
    endtask

    // Leaves the bench at the negedge of the first fetch cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] w0, w1, w2, whi;
        logic        zin;
        logic [15:0] aval, bval;
        int          cycles;
        logic [15:0] exp_pc;
        int          exp_loads;
        int          exp_wr;
        logic        chk;
        logic [3:0]  op, dest, asel, bsel;
        logic        csel, dsel;
        logic [15:0] cin;
    } vec_t;

    vec_t vecs [9];

    int          loads, wrs, both, rd_cnt;
    logic [3:0]  cap_op, cap_dest, cap_a, cap_b;
    logic        cap_csel, cap_dsel;
    logic [15:0] cap_cin;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total %0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        force_ready = 1'b0;
        rd_delay    = 0;
        wr_delay    = 0;
        a_out       = 16'h0000;
        b_out       = 16'h0000;
        z           = 1'b0;

        //          w0       w1       w2       whi     z  a_out    b_out  cyc pc       ld wr chk op    dest  asel  bsel  cs dsl cin
        vecs[0] = '{16'h1123,16'hF000,16'hF000,16'hF000,0,16'h0000,16'h0000,2,16'h0001,1,0,1,4'h1,4'h1,4'h2,4'h3,0,0,16'h0000};
        vecs[1] = '{16'hA500,16'h1234,16'hF000,16'hF000,0,16'h0000,16'h0000,3,16'h0002,1,0,1,4'hF,4'h5,4'h0,4'h0,1,0,16'h1234};
        vecs[2] = '{16'h2345,16'hD000,16'h0040,16'hF000,1,16'h0000,16'h0000,5,16'h0040,1,0,1,4'h2,4'h3,4'h4,4'h5,0,0,16'h0000};
        vecs[3] = '{16'h2345,16'hD000,16'h0040,16'hF000,0,16'h0000,16'h0000,5,16'h0003,1,0,1,4'h2,4'h3,4'h4,4'h5,0,0,16'h0000};
        vecs[4] = '{16'hE000,16'h0077,16'hF000,16'hF000,0,16'h0000,16'h0000,3,16'h0077,0,0,0,4'h0,4'h0,4'h0,4'h0,0,0,16'h0000};
        vecs[5] = '{16'hE000,16'hFFFF,16'hF000,16'h1123,0,16'h0000,16'h0000,5,16'h0000,1,0,1,4'h1,4'h1,4'h2,4'h3,0,0,16'h0000};
        vecs[6] = '{16'hB0A0,16'hF000,16'hF000,16'hF000,0,16'h0100,16'h0000,3,16'h0001,1,0,0,4'h0,4'h0,4'h0,4'h0,0,1,16'h0000};
        vecs[7] = '{16'hC012,16'hF000,16'hF000,16'hF000,0,16'h0100,16'hBEEF,3,16'h0001,0,1,0,4'h0,4'h0,4'h0,4'h0,0,0,16'h0000};
        vecs[8] = '{16'h9ABC,16'hF000,16'hF000,16'hF000,0,16'h0000,16'h0000,2,16'h0001,1,0,1,4'h9,4'hA,4'hB,4'hC,0,0,16'h0000};

        // ---------------- reset state, ready during reset ignored ----------
        fill_mem(16'h1123, 16'hF000, 16'hF000, 16'hF000);
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_rd",  {15'd0, bus.mem_rd}, 16'd0);
        check("rst_mem_wr",  {15'd0, bus.mem_wr}, 16'd0);
        check("rst_load_en", {15'd0, load_en},    16'd0);
        check("rst_halted",  {15'd0, halted},     16'd0);
        check("rst_bus_err", {15'd0, bus_err},    16'd0);
        check("rst_ir_sel",  {4'h0, dest_sel, a_sel, b_sel}, 16'h0000);
        rst_n       = 1'b1;
        force_ready = 1'b0;
        #1;
        check("pre_edge_no_rd", {15'd0, bus.mem_rd}, 16'd0);
        @(negedge clk);
        check("first_fetch_rd",   {15'd0, bus.mem_rd}, 16'd1);
        check("first_fetch_addr", bus.mem_addr, 16'h0000);
        @(negedge clk);
        check("first_exec_load", {15'd0, load_en}, 16'd1);
        check("first_exec_op",   {12'd0, op_sel},  16'h0001);

        // ---------------- vector table ----------------
        for (int v = 0; v < 9; v++) begin
            fill_mem(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].whi);
            z        = vecs[v].zin;
            a_out    = vecs[v].aval;
            b_out    = vecs[v].bval;
            rd_delay = 0;
            wr_delay = 0;
            loads = 0; wrs = 0; both = 0;
            cap_op = 4'h0; cap_dest = 4'h0; cap_a = 4'h0; cap_b = 4'h0;
            cap_csel = 1'b0; cap_dsel = 1'b0; cap_cin = 16'h0;
            do_reset();
            for (int c = 0; c < vecs[v].cycles; c++) begin
                if (load_en) begin
                    loads++;
                    cap_op = op_sel; cap_dest = dest_sel; cap_a = a_sel; cap_b = b_sel;
                    cap_csel = const_sel; cap_dsel = data_sel; cap_cin = const_in;
                end
                if (bus.mem_wr) wrs++;
                if (bus.mem_wr && bus.mem_rd) both++;
                @(negedge clk);
            end
            check($sformatf("v%0d_next_rd", v),  {15'd0, bus.mem_rd}, 16'd1);
            check($sformatf("v%0d_next_pc", v),  bus.mem_addr, vecs[v].exp_pc);
            check($sformatf("v%0d_loads", v),    16'(loads), 16'(vecs[v].exp_loads));
            check($sformatf("v%0d_writes", v),   16'(wrs),   16'(vecs[v].exp_wr));
            check($sformatf("v%0d_rd_wr", v),    16'(both),  16'd0);
            if (vecs[v].exp_loads > 0) begin
                check($sformatf("v%0d_const_sel", v), {15'd0, cap_csel}, {15'd0, vecs[v].csel});
                check($sformatf("v%0d_data_sel", v),  {15'd0, cap_dsel}, {15'd0, vecs[v].dsel});
            end
            if (vecs[v].chk) begin
                check($sformatf("v%0d_op_sel", v),   {12'd0, cap_op},   {12'd0, vecs[v].op});
                check($sformatf("v%0d_dest_sel", v), {12'd0, cap_dest}, {12'd0, vecs[v].dest});
                check($sformatf("v%0d_a_sel", v),    {12'd0, cap_a},    {12'd0, vecs[v].asel});
                check($sformatf("v%0d_b_sel", v),    {12'd0, cap_b},    {12'd0, vecs[v].bsel});
                if (vecs[v].csel)
                    check($sformatf("v%0d_const_in", v), cap_cin, vecs[v].cin);
            end
        end

        // ---------------- store with 3 wait states ----------------
        fill_mem(16'hC012, 16'hF000, 16'hF000, 16'hF000);
        a_out = 16'h0100; b_out = 16'hBEEF; z = 1'b0;
        rd_delay = 0; wr_delay = 3;
        loads = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (load_en) loads++;
            if (c >= 2) begin
                check($sformatf("st_wait%0d_wr", c),   {15'd0, bus.mem_wr}, 16'd1);
                check($sformatf("st_wait%0d_rd", c),   {15'd0, bus.mem_rd}, 16'd0);
                check($sformatf("st_wait%0d_addr", c), bus.mem_addr,  16'h0100);
                check($sformatf("st_wait%0d_data", c), bus.mem_wdata, 16'hBEEF);
            end
            @(negedge clk);
        end
        check("st_done_fetch_addr", bus.mem_addr, 16'h0001);
        check("st_done_wr_low", {15'd0, bus.mem_wr}, 16'd0);
        check("st_no_load", 16'(loads), 16'd0);
        wr_delay = 0;

        // ---------------- halt and reset out of halt ----------------
        fill_mem(16'hF000, 16'hF000, 16'hF000, 16'hF000);
        do_reset();
        repeat (2) @(negedge clk);
        check("halt_halted", {15'd0, halted},     16'd1);
        check("halt_no_rd",  {15'd0, bus.mem_rd}, 16'd0);
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_rd || bus.mem_wr || load_en) rd_cnt++;
        end
        check("halt_quiet", 16'(rd_cnt), 16'd0);
        check("halt_held",  {15'd0, halted}, 16'd1);
        mem[0] = 16'h1123;
        #2 rst_n = 1'b0;
        #1;
        check("halt_async_rst", {15'd0, halted}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("halt_restart_rd",   {15'd0, bus.mem_rd}, 16'd1);
        check("halt_restart_addr", bus.mem_addr, 16'h0000);

        // ---------------- reset mid-access drops strobe at once -----------
        fill_mem(16'h1123, 16'hF000, 16'hF000, 16'hF000);
        rd_delay = 1000;
        do_reset();
        repeat (4) @(negedge clk);
        check("wait_rd_held",   {15'd0, bus.mem_rd}, 16'd1);
        check("wait_addr_held", bus.mem_addr, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_access_rst_rd", {15'd0, bus.mem_rd}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- bus timeout ----------------
        rd_cnt = 0;
`ifdef CU_BUS_TIMEOUT_EN
        for (int c = 0; c < 20; c++) begin
            if (bus.mem_rd) rd_cnt++;
            @(negedge clk);
        end
        check("tmo_rd_cycles", 16'(rd_cnt), 16'd16);
        check("tmo_bus_err",   {15'd0, bus_err},    16'd1);
        check("tmo_halted",    {15'd0, halted},     16'd1);
        check("tmo_rd_low",    {15'd0, bus.mem_rd}, 16'd0);
        check("tmo_wr_low",    {15'd0, bus.mem_wr}, 16'd0);
`else
        for (int c = 0; c < 40; c++) begin
            if (bus.mem_rd) rd_cnt++;
            @(negedge clk);
        end
        check("notmo_rd_cycles", 16'(rd_cnt), 16'd40);
        check("notmo_bus_err",   {15'd0, bus_err}, 16'd0);
        check("notmo_halted",    {15'd0, halted},  16'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: program counter value after reset.
REQ-002 SHALL have parameter PASS_B_OP, default 4'hF: op_sel code the functional unit decodes as F = B.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 mem_addr  out  16  memory address; mem_rd / mem_wr  out  1 each  read/write strobes.
REQ-006 mem_rdata  in  16  read data; mem_wdata  out  16  write data; mem_ready  in  1  access complete.
REQ-007 load_en, const_sel, data_sel  out  1 each; a_sel, b_sel, dest_sel, op_sel  out  4 each; const_in  out  16: datapath controls.
REQ-008 a_out, b_out  in  16 each; z  in  1: datapath results and zero flag.
REQ-009 halted  out  1  controller stopped; bus_err  out  1  bus timeout seen.

Function
REQ-010 SHALL decode ir as [15:12] opcode, [11:8] dest, [7:4] a, [3:0] b; a_sel=ir[7:4], b_sel=ir[3:0], dest_sel=ir[11:8] at all times.
REQ-011 SHALL implement states FETCH, DECODE, IMM, MEM, HALT (plus ERR when REQ-026 applies).
REQ-012 FETCH: mem_rd=1, mem_addr=pc; on mem_ready, ir<=mem_rdata, pc<=pc+1 (16-bit wrap), go DECODE.
REQ-013 DECODE, opcode 0x0-0x9: op_sel=opcode, const_sel=0, data_sel=0, load_en=1 for exactly that cycle, zflag<=z, go FETCH.
REQ-014 DECODE, opcode 0xA (LDI), 0xD (BZ), 0xE (JMP): go IMM.
REQ-015 IMM: mem_rd=1, mem_addr=pc; on mem_ready: LDI -> const_in=mem_rdata, const_sel=1, op_sel=PASS_B_OP, load_en=1, pc<=pc+1; JMP -> pc<=mem_rdata; BZ -> pc<=mem_rdata if zflag else pc+1; go FETCH.
REQ-016 DECODE, opcode 0xB (LD) or 0xC (ST): go MEM.
REQ-017 MEM LD: mem_rd=1, mem_addr=a_out; on mem_ready, data_sel=1, load_en=1 (datapath data_in tied to mem_rdata externally), go FETCH.
REQ-018 MEM ST: mem_wr=1, mem_addr=a_out, mem_wdata=b_out; on mem_ready go FETCH; load_en=0.
REQ-019 DECODE, opcode 0xF: go HALT; HALT holds forever, halted=1, no strobes.
REQ-020 Strobes SHALL stay asserted with stable address/data until mem_ready; mem_rd and mem_wr never both 1.
REQ-021 load_en SHALL be 0 in every cycle not named in REQ-013/015/017; zflag updates only on REQ-013.
REQ-022 Instruction latency without wait states: ALU 2 cycles, LD/ST 3, LDI/JMP/BZ 3.

Reset
REQ-023 rst_n=0 SHALL immediately force state=FETCH, pc=RESET_PC, ir=0, zflag=0, halted=0, bus_err=0, all strobes and load_en 0.
REQ-024 Reset mid-access SHALL drop strobes asynchronously; a mem_ready arriving during reset is ignored.
REQ-025 First fetch SHALL issue on the first clk edge after rst_n rises, at RESET_PC.

Configuration
REQ-026 With CU_BUS_TIMEOUT_EN defined: a cycle counter SHALL count cycles a strobe is held; at 16 cycles without mem_ready, drop strobes, bus_err<=1, enter ERR (halted=1, exit only by reset).
REQ-027 Without CU_BUS_TIMEOUT_EN: no counter, no ERR state, bus_err tied 0, wait indefinitely.

Verification
REQ-028 Reset, mem_ready=1 always, mem[0]=16'h1123 -> fetch at 0, next cycle load_en=1, op_sel=1, dest_sel=1, a_sel=2, b_sel=3; pc=1.
REQ-029 mem[0]=16'hA500, mem[1]=16'h1234 -> IMM cycle load_en=1, const_sel=1, const_in=16'h1234, op_sel=4'hF, dest_sel=5; pc=2.
REQ-030 ALU op with z=1, then BZ (16'hD000, target 16'h0040) -> pc=16'h0040; repeat with z=0 -> pc=3.
REQ-031 ST 16'hC012 with a_out=16'h0100, b_out=16'hBEEF, mem_ready delayed 3 cycles -> mem_wr=1, addr/data stable 4 cycles, load_en never 1.
REQ-032 16'hF000 fetched -> halted=1, no further mem_rd; rst_n pulse low mid-HALT -> fetch restarts at RESET_PC.
REQ-033 With CU_BUS_TIMEOUT_EN, mem_ready held 0 -> after 16 cycles of mem_rd, bus_err=1, halted=1, strobes 0.
